// File: rtl/hpi_access_sequencer.sv
// Round-robin sequencer for CY7C67200 HPI read/write bus cycles shared by two requesters.
// Define HPI_RESET_SEQ_EN to hold hpi_reset_n low for RESET_CYC cycles after reset.
module hpi_access_sequencer #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2,
  parameter int RESET_CYC  = 200
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [1:0]  req0_addr,
  input  logic [15:0] req0_wdata,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_rdata,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [1:0]  req1_addr,
  input  logic [15:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_rdata,
  input  logic [15:0] hpi_data_in,
  output logic [15:0] hpi_data_out,
  output logic        hpi_data_oe,
  output logic [1:0]  hpi_addr,
  output logic        hpi_cs_n,
  output logic        hpi_r_n,
  output logic        hpi_w_n,
  output logic        hpi_reset_n,
  output logic        busy
);

  typedef enum logic [2:0] {RST_HOLD, IDLE, SETUP, STROBE, HOLD} state_t;

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       grant, grant_port, active;
  logic       last_grant_reg, lat_write_reg, lat_port_reg, done_reg;

  assign active = (state_reg == SETUP) || (state_reg == STROBE) || (state_reg == HOLD);

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
`ifdef HPI_RESET_SEQ_EN
      state_reg <= RST_HOLD;
`else
      state_reg <= IDLE;
`endif
      cnt_reg <= 8'(RESET_CYC);
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // One shared down-counter: loaded with the phase length on entry, phase ends when it reads 1.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    grant      = 1'b0;
    grant_port = (req0_valid && req1_valid) ? ~last_grant_reg : req1_valid;
    case (state_reg)
`ifdef HPI_RESET_SEQ_EN
      RST_HOLD: begin
        cnt_next = cnt_reg - 8'd1;
        if (cnt_reg == 8'd1) state_next = IDLE;
      end
`endif
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant      = 1'b1;
          state_next = SETUP;
          cnt_next   = 8'(SETUP_CYC);
        end
      end
      SETUP: begin
        cnt_next = cnt_reg - 8'd1;
        if (cnt_reg == 8'd1) begin
          state_next = STROBE;
          cnt_next   = 8'(STROBE_CYC);
        end
      end
      STROBE: begin
        cnt_next = cnt_reg - 8'd1;
        if (cnt_reg == 8'd1) begin
          state_next = HOLD;
          cnt_next   = 8'(HOLD_CYC);
        end
      end
      HOLD: begin
        cnt_next = cnt_reg - 8'd1;
        if (cnt_reg == 8'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus pins are registered decodes of the current state, so they trail the FSM by one cycle.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      hpi_cs_n       <= 1'b1;
      hpi_r_n        <= 1'b1;
      hpi_w_n        <= 1'b1;
      hpi_data_oe    <= 1'b0;
      hpi_addr       <= 2'd0;
      hpi_data_out   <= 16'd0;
      req0_ready     <= 1'b0;
      req1_ready     <= 1'b0;
      rsp0_valid     <= 1'b0;
      rsp1_valid     <= 1'b0;
      rsp0_rdata     <= 16'd0;
      rsp1_rdata     <= 16'd0;
      busy           <= 1'b1;
      last_grant_reg <= 1'b1;
      lat_write_reg  <= 1'b0;
      lat_port_reg   <= 1'b0;
      done_reg       <= 1'b0;
`ifdef HPI_RESET_SEQ_EN
      hpi_reset_n    <= 1'b0;
`endif
    end else begin
      req0_ready <= grant && !grant_port;
      req1_ready <= grant && grant_port;
      if (grant) begin
        last_grant_reg <= grant_port;
        lat_port_reg   <= grant_port;
        lat_write_reg  <= grant_port ? req1_write : req0_write;
        hpi_addr       <= grant_port ? req1_addr  : req0_addr;
        hpi_data_out   <= grant_port ? req1_wdata : req0_wdata;
      end
      hpi_cs_n    <= !active;
      hpi_data_oe <= active && lat_write_reg;
      hpi_r_n     <= !((state_reg == STROBE) && !lat_write_reg);
      hpi_w_n     <= !((state_reg == STROBE) && lat_write_reg);
      // First HOLD cycle with r_n still low is the edge that closes the read strobe.
      if ((state_reg == HOLD) && !hpi_r_n) begin
        if (lat_port_reg) rsp1_rdata <= hpi_data_in;
        else              rsp0_rdata <= hpi_data_in;
      end
      done_reg   <= (state_reg == HOLD) && (state_next == IDLE);
      rsp0_valid <= done_reg && !lat_port_reg;
      rsp1_valid <= done_reg && lat_port_reg;
      busy       <= (state_next != IDLE);
`ifdef HPI_RESET_SEQ_EN
      hpi_reset_n <= (state_next != RST_HOLD);
`endif
    end
  end

`ifndef HPI_RESET_SEQ_EN
  assign hpi_reset_n = 1'b1;
`endif

endmodule

// File: tb/tb_hpi_access_sequencer.sv
// Randomized two-port bench for hpi_access_sequencer checked cycle by cycle against a
// transaction-window reference model.
module tb_hpi_access_sequencer;

  localparam int S = 1, P = 4, H = 2, W = S + P + H;
  localparam int RESET_CYC = 200;
  localparam int N_CYC = 6000;
`ifdef HPI_RESET_SEQ_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v [2];
  logic        wr [2];
  logic [1:0]  a [2];
  logic [15:0] wd [2];
  logic [15:0] din;
  logic        ready0, ready1, rsp_v0, rsp_v1;
  logic [15:0] rd0, rd1, dout;
  logic        oe, cs_n, r_n, w_n, hrst_n, busy;
  logic [1:0]  haddr;

  always #5 clk = ~clk;

  hpi_access_sequencer #(.SETUP_CYC(S), .STROBE_CYC(P), .HOLD_CYC(H), .RESET_CYC(RESET_CYC)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .req0_valid(v[0]), .req0_write(wr[0]), .req0_addr(a[0]), .req0_wdata(wd[0]),
    .req0_ready(ready0), .rsp0_valid(rsp_v0), .rsp0_rdata(rd0),
    .req1_valid(v[1]), .req1_write(wr[1]), .req1_addr(a[1]), .req1_wdata(wd[1]),
    .req1_ready(ready1), .rsp1_valid(rsp_v1), .rsp1_rdata(rd1),
    .hpi_data_in(din), .hpi_data_out(dout), .hpi_data_oe(oe), .hpi_addr(haddr),
    .hpi_cs_n(cs_n), .hpi_r_n(r_n), .hpi_w_n(w_n), .hpi_reset_n(hrst_n), .busy(busy)
  );

  typedef struct {
    bit          valid;
    int          t0;
    bit          port;
    bit          write;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] din;
  } tx_t;

  int n_cmp = 0;
  int n_err = 0;
  int t = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  tx_t         cur, prev, x;
  tx_t         pair [2];
  logic [15:0] rdata_exp [2];
  bit          ev [2];
  bit          rst_sampled, last_grant, gp, act, stb;
  bit          rdy_obs [2];
  int          rst_cnt, next_forced, idle_from, hold_end;

  initial begin
    for (int n = 0; n < 2; n++) begin
      v[n] = 1'b0; wr[n] = 1'b0; a[n] = 2'd0; wd[n] = 16'd0; rdata_exp[n] = 16'd0;
    end
    din = 16'd0;
    cur = '{1'b0, 0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0};
    prev = cur;
    last_grant = 1'b1;
    rst_cnt = 3;
    next_forced = 300;
    idle_from = 0;
    hold_end = 0;

    while (t < N_CYC) begin
      @(negedge clk);
      t++;
      rst_sampled = rst_n;

      if (!rst_sampled) begin
        check_value("rst_cs_n", cs_n, 1'b1);
        check_value("rst_r_n", r_n, 1'b1);
        check_value("rst_w_n", w_n, 1'b1);
        check_value("rst_oe", oe, 1'b0);
        check_value("rst_addr", haddr, 2'd0);
        check_value("rst_dout", dout, 16'd0);
        check_value("rst_ready0", ready0, 1'b0);
        check_value("rst_ready1", ready1, 1'b0);
        check_value("rst_rsp0", rsp_v0, 1'b0);
        check_value("rst_rsp1", rsp_v1, 1'b0);
        check_value("rst_rdata0", rd0, 16'd0);
        check_value("rst_rdata1", rd1, 16'd0);
        check_value("rst_busy", busy, 1'b1);
        check_value("rst_hpi_reset_n", hrst_n, !SEQ);
      end else begin
        act = cur.valid && (t >= cur.t0 + 1) && (t <= cur.t0 + W);
        stb = cur.valid && (t >= cur.t0 + S + 1) && (t <= cur.t0 + S + P);
        check_value("cs_n", cs_n, !act);
        check_value("r_n", r_n, !(stb && !cur.write));
        check_value("w_n", w_n, !(stb && cur.write));
        check_value("oe", oe, act && cur.write);
        if (act) check_value("addr", haddr, cur.addr);
        if (act && cur.write) check_value("data_out", dout, cur.wdata);
        check_value("ready0", ready0, cur.valid && cur.t0 == t && cur.port == 1'b0);
        check_value("ready1", ready1, cur.valid && cur.t0 == t && cur.port == 1'b1);
        check_value("busy", busy, (SEQ && t < hold_end) || (cur.valid && t >= cur.t0 && t < cur.t0 + W));
        check_value("hpi_reset_n", hrst_n, !SEQ || t >= hold_end);

        ev[0] = 1'b0; ev[1] = 1'b0;
        pair[0] = prev; pair[1] = cur;
        for (int k = 0; k < 2; k++) begin
          x = pair[k];
          if (x.valid && t == x.t0 + W + 1) begin
            ev[x.port] = 1'b1;
            if (!x.write) rdata_exp[x.port] = x.din;
            $display("txn port=%0d %s addr=%0d data=%h done cycle=%0d", x.port,
                     x.write ? "write" : "read", x.addr, x.write ? x.wdata : x.din, t);
          end
        end
        check_value("rsp0_valid", rsp_v0, ev[0]);
        check_value("rsp1_valid", rsp_v1, ev[1]);
        if (ev[0]) check_value("rsp0_rdata", rd0, rdata_exp[0]);
        if (ev[1]) check_value("rsp1_rdata", rd1, rdata_exp[1]);
      end
      check_value("strobe_overlap", !r_n && !w_n, 1'b0);
      check_value("strobe_without_cs", (!r_n || !w_n) && cs_n, 1'b0);

      // Stimulus for the coming clock edge: reset events, requester behaviour, pin data.
      if (rst_n) begin
        if ((t >= next_forced && cur.valid && cur.write && t == cur.t0 + S + P) ||
            $urandom_range(0, 2999) == 0) begin
          rst_n = 1'b0;
          rst_cnt = $urandom_range(0, 2);
          if (t >= next_forced) next_forced = t + 900;
        end
      end else if (rst_cnt == 0) begin
        rst_n = 1'b1;
      end else begin
        rst_cnt--;
      end
      rdy_obs[0] = ready0;
      rdy_obs[1] = ready1;
      for (int n = 0; n < 2; n++) begin
        if (!v[n] || rdy_obs[n]) begin
          v[n] = ($urandom_range(0, 3) != 0);
          wr[n] = $urandom_range(0, 1);
          a[n] = 2'($urandom_range(0, 3));
          wd[n] = 16'($urandom);
        end else if ($urandom_range(0, 63) == 0) begin
          v[n] = 1'b0;
        end
      end
      din = 16'($urandom);

      // Reference model: decide what the coming edge does.
      if (!rst_n) begin
        cur.valid = 1'b0;
        prev.valid = 1'b0;
        last_grant = 1'b1;
        rdata_exp[0] = 16'd0;
        rdata_exp[1] = 16'd0;
      end else begin
        if (!rst_sampled) begin
          hold_end = SEQ ? t + RESET_CYC : t;
          idle_from = hold_end;
        end
        if (cur.valid && t == cur.t0 + S + P) cur.din = din;
        if (t >= idle_from && (v[0] || v[1])) begin
          gp = (v[0] && v[1]) ? !last_grant : v[1];
          prev = cur;
          cur = '{1'b1, t + 1, gp, wr[gp], a[gp], wd[gp], 16'd0};
          last_grant = gp;
          idle_from = t + 1 + W;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
